// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles, most significant first, into NIBBLES-wide words.
// The output is a valid/ready register, and a single completed word can wait in the assembly register.
module nibble_packer #(
  parameter int          NIBBLES = 8,
  parameter logic [3:0]  PAD     = 4'h0
) (
  input  logic                   CLK,
  input  logic                   RESET_L,
  input  logic [4:0]             DATA_IN,
  input  logic                   FLUSH,
  input  logic                   READY_IN,
  output logic [4*NIBBLES-1:0]   DATA_OUT,
  output logic                   VALID_OUT,
  output logic [3:0]             NIB_CNT_OUT,
  output logic [3:0]             COUNT,
  output logic                   FULL,
  output logic                   DROP
);

  localparam int         W        = 4*NIBBLES;
  localparam logic [3:0] FULL_CNT = 4'(NIBBLES);

  logic [W-1:0] asm_q, asm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] dout_q, dout_d;
  logic         vout_q, vout_d;
  logic [3:0]   ncnt_q, ncnt_d;
  logic [3:0]   hcnt_q, hcnt_d;
  logic         drop_q, drop_d;

  logic         acc;
  logic         hold;
  logic         run_fill;
  logic         fill_slot_free;
  logic [W-1:0] base_asm;
  logic [3:0]   base_cnt;
  logic [3:0]   eff;
  logic [W-1:0] asm_w;
  logic [W-1:0] padded;
  logic         complete;

  always_comb begin
    asm_d          = asm_q;
    cnt_d          = cnt_q;
    dout_d         = dout_q;
    vout_d         = vout_q;
    ncnt_d         = ncnt_q;
    hcnt_d         = hcnt_q;
    drop_d         = 1'b0;
    acc            = DATA_IN[4];
    hold           = (cnt_q == FULL_CNT);
    run_fill       = 1'b1;
    fill_slot_free = !vout_q | READY_IN;
    base_asm       = asm_q;
    base_cnt       = cnt_q;

    // A draining HOLD edge fills the slot with the held word, so new content
    // starts from an empty register and any completion on this edge must wait.
    if (hold) begin
      if (READY_IN) begin
        dout_d         = asm_q;
        ncnt_d         = hcnt_q;
        vout_d         = 1'b1;
        base_asm       = '0;
        base_cnt       = '0;
        fill_slot_free = 1'b0;
      end else begin
        drop_d   = acc;
        run_fill = 1'b0;
      end
    end else if (vout_q && READY_IN) begin
      vout_d = 1'b0;
    end

    eff   = base_cnt + {3'b000, acc};
    asm_w = base_asm;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (acc && (base_cnt == 4'(i)))
        asm_w[W-1-4*i -: 4] = DATA_IN[3:0];
    end
    padded = asm_w;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (4'(i) >= eff)
        padded[W-1-4*i -: 4] = PAD;
    end
    complete = (eff == FULL_CNT) || (FLUSH && (eff != 4'd0));

    if (run_fill) begin
      if (complete) begin
        if (fill_slot_free) begin
          dout_d = padded;
          ncnt_d = eff;
          vout_d = 1'b1;
          asm_d  = '0;
          cnt_d  = '0;
        end else begin
          asm_d  = padded;
          cnt_d  = FULL_CNT;
          hcnt_d = eff;
        end
      end else begin
        asm_d = asm_w;
        cnt_d = eff;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      ncnt_q <= '0;
      hcnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      ncnt_q <= ncnt_d;
      hcnt_q <= hcnt_d;
      drop_q <= drop_d;
    end
  end

  assign DATA_OUT    = dout_q;
  assign VALID_OUT   = vout_q;
  assign NIB_CNT_OUT = ncnt_q;
  assign COUNT       = cnt_q;
  assign FULL        = (cnt_q == FULL_CNT);
  assign DROP        = drop_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed-vector bench for nibble_packer: one task per scenario, inline comparisons.
module tb_nibble_packer;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic [4:0]  DATA_IN;
  logic        FLUSH;
  logic        READY_IN;
  logic [31:0] DATA_OUT;
  logic        VALID_OUT;
  logic [3:0]  NIB_CNT_OUT;
  logic [3:0]  COUNT;
  logic        FULL;
  logic        DROP;

  int passed = 0;
  int total  = 0;

  nibble_packer #(.NIBBLES(8), .PAD(4'h0)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .DATA_IN(DATA_IN), .FLUSH(FLUSH),
    .READY_IN(READY_IN), .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT),
    .NIB_CNT_OUT(NIB_CNT_OUT), .COUNT(COUNT), .FULL(FULL), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  // Drive one edge's inputs, let the edge happen, then leave outputs settled for sampling.
  task automatic cyc(input logic v, input logic [3:0] n, input logic fl, input logic rdy);
    DATA_IN  = {v, n};
    FLUSH    = fl;
    READY_IN = rdy;
    @(posedge CLK);
    #1;
    DATA_IN = 5'd0;
    FLUSH   = 1'b0;
  endtask

  task automatic test_reset();
    RESET_L = 1'b0; DATA_IN = 5'd0; FLUSH = 1'b0; READY_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (DATA_OUT !== 32'h0) $display("FAIL reset_data got %h exp %h", DATA_OUT, 32'h0); else passed++;
    total++; if (VALID_OUT !== 1'b0) $display("FAIL reset_valid got %b exp 0", VALID_OUT); else passed++;
    total++; if (NIB_CNT_OUT !== 4'd0) $display("FAIL reset_nibcnt got %0d exp 0", NIB_CNT_OUT); else passed++;
    total++; if (COUNT !== 4'd0) $display("FAIL reset_count got %0d exp 0", COUNT); else passed++;
    total++; if ({FULL, DROP} !== 2'b00) $display("FAIL reset_full_drop got %b exp 00", {FULL, DROP}); else passed++;
    RESET_L = 1'b1;
  endtask

  task automatic test_single_word();
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 4'(k), 1'b0, 1'b1);
      total++; if (COUNT !== 4'(k + 1)) $display("FAIL single_count got %0d exp %0d", COUNT, k + 1); else passed++;
      total++; if (VALID_OUT !== 1'b0) $display("FAIL single_early_valid got %b exp 0", VALID_OUT); else passed++;
    end
    cyc(1'b1, 4'd7, 1'b0, 1'b1);
    total++; if (VALID_OUT !== 1'b1) $display("FAIL single_valid got %b exp 1", VALID_OUT); else passed++;
    total++; if (DATA_OUT !== 32'h01234567) $display("FAIL single_data got %h exp %h", DATA_OUT, 32'h01234567); else passed++;
    total++; if (NIB_CNT_OUT !== 4'd8) $display("FAIL single_nibcnt got %0d exp 8", NIB_CNT_OUT); else passed++;
    total++; if (COUNT !== 4'd0) $display("FAIL single_count_end got %0d exp 0", COUNT); else passed++;
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    total++; if (VALID_OUT !== 1'b0) $display("FAIL single_valid_clear got %b exp 0", VALID_OUT); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 4'((k + 8) % 16), 1'b0, 1'b1);
      if (k == 7) begin
        total++; if (DATA_OUT !== 32'h89ABCDEF || VALID_OUT !== 1'b1) $display("FAIL b2b_word0 got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h89ABCDEF); else passed++;
      end
      if (k == 8) begin
        total++; if (VALID_OUT !== 1'b0) $display("FAIL b2b_taken got %b exp 0", VALID_OUT); else passed++;
      end
    end
    total++; if (DATA_OUT !== 32'h01234567 || VALID_OUT !== 1'b1) $display("FAIL b2b_word1 got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h01234567); else passed++;
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    total++; if (VALID_OUT !== 1'b0) $display("FAIL b2b_end got %b exp 0", VALID_OUT); else passed++;
  endtask

  task automatic test_flush();
    cyc(1'b1, 4'h9, 1'b0, 1'b1);
    cyc(1'b1, 4'hA, 1'b0, 1'b1);
    cyc(1'b1, 4'hB, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    total++; if (DATA_OUT !== 32'h9AB00000 || VALID_OUT !== 1'b1) $display("FAIL flush_data got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h9AB00000); else passed++;
    total++; if (NIB_CNT_OUT !== 4'd3) $display("FAIL flush_nibcnt got %0d exp 3", NIB_CNT_OUT); else passed++;
    total++; if (COUNT !== 4'd0) $display("FAIL flush_count got %0d exp 0", COUNT); else passed++;
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    total++; if (VALID_OUT !== 1'b0 || COUNT !== 4'd0) $display("FAIL flush_empty got %b/%0d exp 0/0", VALID_OUT, COUNT); else passed++;
    for (int k = 1; k < 8; k++) cyc(1'b1, 4'(k), 1'b0, 1'b1);
    cyc(1'b1, 4'd8, 1'b1, 1'b1);
    total++; if (DATA_OUT !== 32'h12345678 || NIB_CNT_OUT !== 4'd8) $display("FAIL flush_8th got %h/%0d exp %h/8", DATA_OUT, NIB_CNT_OUT, 32'h12345678); else passed++;
    cyc(1'b1, 4'd3, 1'b1, 1'b1);
    total++; if (DATA_OUT !== 32'h30000000 || NIB_CNT_OUT !== 4'd1) $display("FAIL flush_one got %h/%0d exp %h/1", DATA_OUT, NIB_CNT_OUT, 32'h30000000); else passed++;
    cyc(1'b1, 4'd4, 1'b1, 1'b1);
    total++; if (DATA_OUT !== 32'h40000000 || VALID_OUT !== 1'b1) $display("FAIL flush_reload got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h40000000); else passed++;
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    total++; if (VALID_OUT !== 1'b0) $display("FAIL flush_end got %b exp 0", VALID_OUT); else passed++;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 4'(k), 1'b0, 1'b0);
      if (k == 7) begin
        total++; if (DATA_OUT !== 32'h01234567 || VALID_OUT !== 1'b1) $display("FAIL stall_first got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h01234567); else passed++;
      end
      if (k == 14) begin
        total++; if (FULL !== 1'b0 || COUNT !== 4'd7) $display("FAIL stall_prefull got %b/%0d exp 0/7", FULL, COUNT); else passed++;
      end
    end
    total++; if (DATA_OUT !== 32'h01234567 || VALID_OUT !== 1'b1) $display("FAIL stall_stable got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h01234567); else passed++;
    total++; if (FULL !== 1'b1 || COUNT !== 4'd8) $display("FAIL stall_full got %b/%0d exp 1/8", FULL, COUNT); else passed++;
    total++; if (DROP !== 1'b0) $display("FAIL stall_nodrop got %b exp 0", DROP); else passed++;
    cyc(1'b1, 4'd5, 1'b0, 1'b0);
    total++; if (DROP !== 1'b1) $display("FAIL stall_drop got %b exp 1", DROP); else passed++;
    total++; if (DATA_OUT !== 32'h01234567 || COUNT !== 4'd8) $display("FAIL stall_after_drop got %h/%0d exp %h/8", DATA_OUT, COUNT, 32'h01234567); else passed++;
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    total++; if (DATA_OUT !== 32'h89ABCDEF || VALID_OUT !== 1'b1) $display("FAIL stall_drain got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h89ABCDEF); else passed++;
    total++; if (COUNT !== 4'd0 || FULL !== 1'b0 || DROP !== 1'b0) $display("FAIL stall_drain_state got %0d/%b/%b exp 0/0/0", COUNT, FULL, DROP); else passed++;
    total++; if (NIB_CNT_OUT !== 4'd8) $display("FAIL stall_drain_nibcnt got %0d exp 8", NIB_CNT_OUT); else passed++;
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    total++; if (VALID_OUT !== 1'b0) $display("FAIL stall_end got %b exp 0", VALID_OUT); else passed++;
  endtask

  task automatic test_drain_nibble();
    for (int k = 0; k < 16; k++) cyc(1'b1, 4'(k), 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b0, 1'b1);
    total++; if (DATA_OUT !== 32'h89ABCDEF || VALID_OUT !== 1'b1) $display("FAIL drainnib_data got %h/%b exp %h/1", DATA_OUT, VALID_OUT, 32'h89ABCDEF); else passed++;
    total++; if (COUNT !== 4'd1 || DROP !== 1'b0) $display("FAIL drainnib_state got %0d/%b exp 1/0", COUNT, DROP); else passed++;
    for (int k = 1; k < 8; k++) cyc(1'b1, 4'(k), 1'b0, 1'b1);
    total++; if (DATA_OUT !== 32'hC1234567 || NIB_CNT_OUT !== 4'd8) $display("FAIL drainnib_next got %h/%0d exp %h/8", DATA_OUT, NIB_CNT_OUT, 32'hC1234567); else passed++;
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 13; k++) cyc(1'b1, 4'(k % 8), 1'b0, 1'b0);
    total++; if (VALID_OUT !== 1'b1 || COUNT !== 4'd5) $display("FAIL rstmid_pre got %b/%0d exp 1/5", VALID_OUT, COUNT); else passed++;
    RESET_L = 1'b0;
    #2;
    total++; if (DATA_OUT !== 32'h0 || VALID_OUT !== 1'b0) $display("FAIL rstmid_out got %h/%b exp 0/0", DATA_OUT, VALID_OUT); else passed++;
    total++; if (COUNT !== 4'd0 || NIB_CNT_OUT !== 4'd0 || FULL !== 1'b0) $display("FAIL rstmid_state got %0d/%0d/%b exp 0/0/0", COUNT, NIB_CNT_OUT, FULL); else passed++;
    @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    for (int k = 0; k < 7; k++) cyc(1'b1, 4'(15 - k), 1'b0, 1'b1);
    total++; if (VALID_OUT !== 1'b0 || COUNT !== 4'd7) $display("FAIL rstmid_nostale got %b/%0d exp 0/7", VALID_OUT, COUNT); else passed++;
    cyc(1'b1, 4'h8, 1'b0, 1'b1);
    total++; if (DATA_OUT !== 32'hFEDCBA98 || NIB_CNT_OUT !== 4'd8 || VALID_OUT !== 1'b1) $display("FAIL rstmid_new got %h/%0d/%b exp %h/8/1", DATA_OUT, NIB_CNT_OUT, VALID_OUT, 32'hFEDCBA98); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_flush();
    test_stall();
    test_drain_nibble();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Nibble packer: the write-side counterpart of the nibble selector. It takes a stream of 5-bit nibble words (valid bit plus 4-bit nibble), the same format the nibble selector drives on DATA_OUT. It assembles them, most significant nibble first, into 32-bit words, the same layout the selector reads on DATA_A/DATA_B. Completed words are presented on a valid/ready output register. A zero-padded partial word can be forced out with FLUSH. A stalled output holds the completed word; input arriving during the stall is counted as dropped.

## Interface

Parameters
- NIBBLES, default 8: nibbles per output word; word width is 4*NIBBLES. Only 8 is verified.
- PAD, default 4'h0: nibble value written into unfilled positions on FLUSH.

Ports
- CLK  input  1  single clock; all state updates on rising edge.
- RESET_L  input  1  reset, asynchronous, active-low.
- DATA_IN  input  5  nibble input. [4] = valid; [3:0] = nibble.
- FLUSH  input  1  close the current partial word, sampled on the rising edge.
- READY_IN  input  1  downstream can take DATA_OUT this cycle.
- DATA_OUT  output  32  assembled word. Nibble 0 is in [31:28]; nibble 7 is in [3:0].
- VALID_OUT  output  1  DATA_OUT holds an untaken word.
- NIB_CNT_OUT  output  4  number of real nibbles in DATA_OUT (1..8).
- COUNT  output  4  number of nibbles currently held in the assembly register (0..8).
- FULL  output  1  assembly register is complete and waiting for the output slot.
- DROP  output  1  one-cycle pulse: a valid nibble was discarded on the previous edge.

## Operation

- Storage: assembly register ASM[31:0] with count CNT, plus output register DATA_OUT with VALID_OUT and NIB_CNT_OUT.
- State machine (state is implied by CNT):
  - EMPTY (CNT=0).
  - FILL (CNT 1..7).
  - HOLD (CNT=8; FULL=1).
- Output slot free this cycle: SLOT_FREE = !VALID_OUT | READY_IN.
- Output transfer: a word is taken when VALID_OUT & READY_IN at an edge. If nothing reloads the slot on that edge, VALID_OUT clears.
- Nibble accept (EMPTY or FILL, DATA_IN[4]=1):
  - Nibble is written to position CNT, i.e. ASM[31-4*CNT -: 4].
  - CNT increments.
- Word completion. On the edge where the accepted nibble makes CNT reach 8, or where FLUSH=1 with effective count 1..7:
  - If SLOT_FREE: the completed word, including that edge's nibble, loads into DATA_OUT. Unfilled positions take PAD. NIB_CNT_OUT = effective count, VALID_OUT=1, CNT returns to 0.
  - Otherwise: the word is held in ASM with unfilled positions set to PAD. CNT=8 and the state is HOLD. NIB_CNT_OUT for the held word is latched in a shadow register.
- HOLD:
  - Drain edge (READY_IN=1): ASM moves into DATA_OUT with its latched count, and VALID_OUT stays 1. A valid nibble on that same edge becomes nibble 0 of the new ASM (CNT=1). FLUSH on that edge applies to the new content only.
  - Non-drain edge (READY_IN=0): a valid DATA_IN is discarded, and DROP=1 on the following cycle. FLUSH is ignored.
- FLUSH with effective count 0 (EMPTY, no valid nibble): no operation, no output.
- Invalid input (DATA_IN[4]=0): no change to ASM or CNT.

## Timing

- Reset (RESET_L low, asynchronous): DATA_OUT=0, VALID_OUT=0, NIB_CNT_OUT=0, COUNT=0, FULL=0, DROP=0, ASM=0, state EMPTY. Effective immediately, without waiting for a clock edge.
- Reset released mid-word: the partial word is lost and is not flushed.
- Throughput: one nibble per cycle, with no bubbles while the output drains every cycle.
- Latency: VALID_OUT is high in the cycle right after the edge that accepts the 8th nibble (or the flush edge).
- All outputs are registered. COUNT and FULL reflect state after the last edge.
- DATA_OUT, NIB_CNT_OUT and VALID_OUT remain stable while VALID_OUT=1 and READY_IN=0.
- Simultaneous events on one edge are legal: output take + completion reload + new nibble accept.
  - The output slot is reloaded; it never shows a gap.
- FLUSH together with the 8th nibble: a normal full word, NIB_CNT_OUT=8.

## Test plan

- Reset held 2 cycles, then 8 valid nibbles 0,1,...,7 on consecutive edges with READY_IN=1 -> DATA_OUT='h01234567, NIB_CNT_OUT=8, VALID_OUT=1 for exactly one cycle, one cycle after the 8th edge.
- 16 nibbles 8..F,0..7 back-to-back with READY_IN=1 -> words 'h89ABCDEF and 'h01234567 on consecutive word slots; VALID_OUT has no gap between them beyond the 8-cycle fill.
- Nibbles 9,A,B, then FLUSH=1 with DATA_IN[4]=0 -> DATA_OUT='h9AB00000, NIB_CNT_OUT=3, COUNT returns to 0.
- READY_IN=0, 17 nibbles 0..F,5 -> DATA_OUT='h01234567 held stable; FULL=1 after the 16th nibble; the 17th is discarded with DROP=1 for one cycle. Then READY_IN=1 -> 'h89ABCDEF follows the next edge, and COUNT=0.
- Stall drain with same-edge nibble: in HOLD, READY_IN=1 together with nibble C -> DATA_OUT = the held word, COUNT=1, no DROP; the next word starts with C in [31:28].
- Reset mid-operation: RESET_L low after 5 nibbles with VALID_OUT=1 -> all outputs 0 immediately. After release, 8 new nibbles produce only the new word.
